robo_controle: RTL and testbench

Left-hand wall-following navigation controller for the maze robot, directly upstream of the map/sensor stage. It consumes the map stage's `head` and `left` obstacle bits and drives that stage's `acao` (move command) and `orientacao` (heading) inputs. It sequences sense/decide/act with explicit settle cycles that absorb the map stage's registered-sensor latency. It counts completed moves and halts on a step budget or on a trapped condition.

---
 rtl/robo_controle.sv | 229 ++++++++++++++++++++++
 tb/tb_robo_controle.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/robo_controle.sv
// robo_controle: left-hand wall-following navigation controller.
// Runs a sense/decide/act loop. The settle cycles between commands cover the
// registered-sensor latency of the map stage. Moves are counted, and the
// controller halts when the step budget is spent or when it detects a trap.
module robo_controle #(
  parameter logic [2:0] INIT_ORIENT   = 3'b001,
  parameter int         MAX_STEPS     = 200,
  parameter int         STEP_W        = 8,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         TRAP_ROT      = 5
) (
  input  logic              clockc1,
  input  logic              reset,
  input  logic              start,
  input  logic              head,
  input  logic              left,
  output logic [2:0]        acao,
  output logic [2:0]        orientacao,
  output logic              busy,
  output logic              done,
  output logic              trapped,
  output logic [STEP_W-1:0] passos
);

  localparam int WAIT_W = (SETTLE_CYCLES < 2) ? 2 : $clog2(SETTLE_CYCLES + 1);
  localparam int ROT_W  = (TRAP_ROT < 2) ? 2 : $clog2(TRAP_ROT + 1);

  localparam logic [WAIT_W-1:0] WAIT_LOAD  = WAIT_W'(SETTLE_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO  = WAIT_W'(0);
  localparam logic [ROT_W-1:0]  ROT_LIMIT  = ROT_W'(TRAP_ROT);
  localparam logic [ROT_W-1:0]  ROT_ONE    = ROT_W'(1);
  localparam logic [ROT_W-1:0]  ROT_ZERO   = ROT_W'(0);
  localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);
  localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_SAT   = {STEP_W{1'b1}};

  // Heading codes
  localparam logic [2:0] H_N = 3'b001;
  localparam logic [2:0] H_W = 3'b010;
  localparam logic [2:0] H_E = 3'b011;
  localparam logic [2:0] H_S = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_DECIDE  = 3'd2,
    S_MOVE    = 3'd3,
    S_HALT    = 3'd4,
    S_TRAPPED = 3'd5
  } state_t;

  // Quarter turn counter-clockwise: N->W->S->E->N
  function automatic logic [2:0] rot_left(input logic [2:0] h);
    logic [2:0] r;
    case (h)
      H_N:     r = H_W;
      H_W:     r = H_S;
      H_S:     r = H_E;
      H_E:     r = H_N;
      default: r = h;
    endcase
    return r;
  endfunction

  // Quarter turn clockwise: N->E->S->W->N
  function automatic logic [2:0] rot_right(input logic [2:0] h);
    logic [2:0] r;
    case (h)
      H_N:     r = H_E;
      H_E:     r = H_S;
      H_S:     r = H_W;
      H_W:     r = H_N;
      default: r = h;
    endcase
    return r;
  endfunction

  // Move command for a heading. S and E use different codes in acao than in orientacao.
  function automatic logic [2:0] move_code(input logic [2:0] h);
    logic [2:0] r;
    case (h)
      H_N:     r = 3'b001;
      H_W:     r = 3'b010;
      H_S:     r = 3'b011;
      H_E:     r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  state_t              r_state;
  state_t              w_next_state;
  logic [WAIT_W-1:0]   r_wait_cnt, w_wait_cnt;
  logic [ROT_W-1:0]    r_rot_cnt, w_rot_cnt;
  logic                r_turned_left, w_turned_left;
  logic [2:0]          r_acao, w_acao;
  logic [2:0]          r_orient, w_orient;
  logic [STEP_W-1:0]   r_passos, w_passos;
  logic                r_busy, r_done, r_trapped;
  logic                w_busy, w_done, w_trapped;
  logic                w_rule_left;
  logic                w_rule_move;
  logic [ROT_W-1:0]    w_rot_inc;

  // Rule 1 (turn left) takes priority. Rule 2 (move ahead) applies only when rule 1 does not.
  assign w_rule_left = ~left & ~r_turned_left;
  assign w_rule_move = ~w_rule_left & ~head;
  assign w_rot_inc   = r_rot_cnt + ROT_ONE;

  // State register
  always_ff @(posedge clockc1 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_WAIT;
        else       w_next_state = S_IDLE;
      end
      S_WAIT: begin
        if (r_wait_cnt <= WAIT_ONE) w_next_state = S_DECIDE;
        else                        w_next_state = S_WAIT;
      end
      S_DECIDE: begin
        if (w_rule_move)                  w_next_state = S_MOVE;
        else if (w_rot_inc == ROT_LIMIT)  w_next_state = S_TRAPPED;
        else                              w_next_state = S_WAIT;
      end
      S_MOVE: begin
        if (r_passos == STEP_LIMIT) w_next_state = S_HALT;
        else                        w_next_state = S_WAIT;
      end
      S_HALT:    w_next_state = S_HALT;
      S_TRAPPED: w_next_state = S_TRAPPED;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Next datapath and output values. acao is a single-cycle pulse, so it defaults to idle.
  always_comb begin
    w_acao        = 3'b000;
    w_orient      = r_orient;
    w_passos      = r_passos;
    w_wait_cnt    = r_wait_cnt;
    w_rot_cnt     = r_rot_cnt;
    w_turned_left = r_turned_left;
    case (r_state)
      S_IDLE: begin
        if (start) w_wait_cnt = WAIT_LOAD;
        else       w_wait_cnt = r_wait_cnt;
      end
      S_WAIT: begin
        if (r_wait_cnt != WAIT_ZERO) w_wait_cnt = r_wait_cnt - WAIT_ONE;
        else                         w_wait_cnt = WAIT_ZERO;
      end
      S_DECIDE: begin
        w_wait_cnt = WAIT_LOAD;
        if (w_rule_left) begin
          w_orient      = rot_left(r_orient);
          w_turned_left = 1'b1;
          w_rot_cnt     = w_rot_inc;
        end else if (w_rule_move) begin
          w_acao        = move_code(r_orient);
          w_turned_left = 1'b0;
          w_rot_cnt     = ROT_ZERO;
          if (r_passos != STEP_SAT) w_passos = r_passos + STEP_ONE;
          else                      w_passos = r_passos;
        end else begin
          w_orient  = rot_right(r_orient);
          w_rot_cnt = w_rot_inc;
        end
      end
      S_MOVE: begin
        w_wait_cnt = WAIT_LOAD;
      end
      S_HALT, S_TRAPPED: begin
        w_wait_cnt = r_wait_cnt;
      end
      default: begin
        w_wait_cnt = WAIT_ZERO;
      end
    endcase
    w_busy    = (w_next_state != S_IDLE) && (w_next_state != S_HALT) &&
                (w_next_state != S_TRAPPED);
    w_done    = (w_next_state == S_HALT);
    w_trapped = (w_next_state == S_TRAPPED);
  end

  // Datapath and output registers. Reset clears any in-flight move pulse at once.
  always_ff @(posedge clockc1 or posedge reset) begin
    if (reset) begin
      r_acao        <= 3'b000;
      r_orient      <= INIT_ORIENT;
      r_passos      <= {STEP_W{1'b0}};
      r_wait_cnt    <= WAIT_ZERO;
      r_rot_cnt     <= ROT_ZERO;
      r_turned_left <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_trapped     <= 1'b0;
    end else begin
      r_acao        <= w_acao;
      r_orient      <= w_orient;
      r_passos      <= w_passos;
      r_wait_cnt    <= w_wait_cnt;
      r_rot_cnt     <= w_rot_cnt;
      r_turned_left <= w_turned_left;
      r_busy        <= w_busy;
      r_done        <= w_done;
      r_trapped     <= w_trapped;
    end
  end

  assign acao       = r_acao;
  assign orientacao = r_orient;
  assign passos     = r_passos;
  assign busy       = r_busy;
  assign done       = r_done;
  assign trapped    = r_trapped;

endmodule

// File: tb/tb_robo_controle.sv
// tb_robo_controle: bench for robo_controle. It drives directed and random
// sensor patterns and compares the outputs every cycle against a
// decision-schedule model of the navigation rules.
module tb_robo_controle;

  localparam int SETTLE = 2;
  localparam int MAXS   = 5;
  localparam int TRAPR  = 5;

  logic       clockc1 = 1'b0;
  logic       reset;
  logic       start, head, left;
  logic [2:0] acao, orientacao;
  logic       busy, done, trapped;
  logic [7:0] passos;

  int checks   = 0;
  int failures = 0;

  robo_controle #(
    .INIT_ORIENT  (3'b001),
    .MAX_STEPS    (MAXS),
    .STEP_W       (8),
    .SETTLE_CYCLES(SETTLE),
    .TRAP_ROT     (TRAPR)
  ) dut (
    .clockc1   (clockc1),
    .reset     (reset),
    .start     (start),
    .head      (head),
    .left      (left),
    .acao      (acao),
    .orientacao(orientacao),
    .busy      (busy),
    .done      (done),
    .trapped   (trapped),
    .passos    (passos)
  );

  always #5 clockc1 = ~clockc1;

  // Model: headings are indexed 0..3 as N,W,S,E, so a left turn adds 1 (mod 4).
  int ORC[4] = '{1, 2, 4, 3};  // orientacao code per index
  int MVC[4] = '{1, 2, 3, 4};  // acao code per index
  int m_mode;       // 0 idle, 1 running, 2 halted, 3 trapped
  int m_until;      // edges left until the next decision
  int m_hd;
  int m_steps;
  int m_rot;
  int m_tl;
  int m_acao;
  int m_halt_pend;

  task automatic chk_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_until = 0; m_hd = 0; m_steps = 0;
    m_rot = 0; m_tl = 0; m_acao = 0; m_halt_pend = 0;
  endtask

  task automatic model_edge(input int st, input int h, input int l);
    if (m_mode == 0) begin
      if (st != 0) begin
        m_mode  = 1;
        m_until = SETTLE + 1;
      end
    end else if (m_mode == 1) begin
      m_acao = 0;
      if (m_halt_pend != 0) begin
        m_mode = 2;
        m_halt_pend = 0;
      end else begin
        m_until--;
        if (m_until == 0) begin
          if (l == 0 && m_tl == 0) begin
            m_hd = (m_hd + 1) % 4;
            m_tl = 1;
            m_rot++;
          end else if (h == 0) begin
            m_acao  = MVC[m_hd];
            m_tl    = 0;
            m_rot   = 0;
            m_steps++;
            m_until = SETTLE + 2;
            if (m_steps == MAXS) m_halt_pend = 1;
          end else begin
            m_hd = (m_hd + 3) % 4;
            m_rot++;
          end
          if (m_acao == 0) begin
            if (m_rot == TRAPR) m_mode = 3;
            else m_until = SETTLE + 1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    chk_val("acao",    int'(acao),       m_acao);
    chk_val("orient",  int'(orientacao), ORC[m_hd]);
    chk_val("passos",  int'(passos),     m_steps);
    chk_val("busy",    int'(busy),       (m_mode == 1) ? 1 : 0);
    chk_val("done",    int'(done),       (m_mode == 2) ? 1 : 0);
    chk_val("trapped", int'(trapped),    (m_mode == 3) ? 1 : 0);
  endtask

  // One clock: inputs are applied after the falling edge and outputs are checked at the next falling edge.
  task automatic cycle(input int st, input int h, input int l);
    start = st[0]; head = h[0]; left = l[0];
    @(posedge clockc1);
    model_edge(st, h, l);
    @(negedge clockc1);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clockc1);
    compare_all();
    reset = 1'b0;
  endtask

  initial begin
    bit found;
    int ps, ph, pl;
    reset = 1'b1; start = 1'b0; head = 1'b0; left = 1'b0;
    model_reset();
    @(negedge clockc1);
    compare_all();
    reset = 1'b0;

    // Open field: one move every SETTLE+2 cycles until the budget is spent. Later starts are ignored.
    cycle(1, 0, 1);
    for (int i = 0; i < 30; i++) cycle(0, 0, 1);
    chk_val("halt_done", int'(done), 1);
    chk_val("halt_steps", int'(passos), MAXS);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0);

    // Left always open: left turn, then move, repeated.
    do_reset();
    cycle(1, 0, 0);
    for (int i = 0; i < 24; i++) cycle(0, 0, 0);

    // Boxed in: right turns only, then trapped on the fifth rotation.
    do_reset();
    cycle(1, 1, 1);
    for (int i = 0; i < 20; i++) cycle(0, 1, 1);
    chk_val("trap_flag", int'(trapped), 1);
    chk_val("trap_orient", int'(orientacao), 3);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0);

    // Reset applied in the middle of a move pulse.
    do_reset();
    cycle(1, 0, 1);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle(0, 0, 1);
      if (acao != 3'b000) found = 1'b1;
    end
    chk_val("move_seen", int'(found), 1);
    reset = 1'b1;
    #1;
    chk_val("rst_acao", int'(acao), 0);
    chk_val("rst_orient", int'(orientacao), 1);
    chk_val("rst_passos", int'(passos), 0);
    model_reset();
    @(negedge clockc1);
    reset = 1'b0;
    compare_all();
    cycle(1, 0, 1);
    for (int i = 0; i < 12; i++) cycle(0, 0, 1);

    // Randomized rounds with varied obstacle densities and occasional resets.
    for (int r = 0; r < 10; r++) begin
      do_reset();
      ph = $urandom_range(10, 90);
      pl = $urandom_range(10, 90);
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 199) == 0) begin
          do_reset();
        end else begin
          ps = ($urandom_range(0, 3) == 0) ? 1 : 0;
          cycle(ps, ($urandom_range(0, 99) < ph) ? 1 : 0,
                    ($urandom_range(0, 99) < pl) ? 1 : 0);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
